// File: rtl/cacheline_adaptor.sv
// Bridges one full-line cache memory request onto a narrower burst memory.
// The line moves lowest beat first, and completion is a single-cycle pmem_resp.
module cacheline_adaptor #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [ADDR_WIDTH-1:0] pmem_address,
    input  logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic [LINE_WIDTH-1:0] pmem_rdata,
    output logic                  pmem_resp,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [ADDR_WIDTH-1:0] burst_address,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp
);

    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t                           state_q, state_d;
    logic [CW-1:0]                    cnt_q, cnt_d, cnt_inc;
    logic [BEATS-1:0][BEAT_WIDTH-1:0] line_q, line_d;
    logic [LINE_WIDTH-1:0]            rdata_d;
    logic                             resp_d, bread_d, bwrite_d;
    logic [ADDR_WIDTH-1:0]            baddr_d;
    logic [BEAT_WIDTH-1:0]            bwdata_d;

    // Counter wraps to zero on the final beat, even for non power-of-two BEATS
    assign cnt_inc = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        line_d   = line_q;
        rdata_d  = pmem_rdata;
        resp_d   = 1'b0;
        bread_d  = burst_read;
        bwrite_d = burst_write;
        baddr_d  = burst_address;
        bwdata_d = burst_wdata;
        unique case (state_q)
            IDLE: begin
                if (pmem_write) begin
                    line_d   = pmem_wdata;
                    baddr_d  = pmem_address & AMASK;
                    bwdata_d = pmem_wdata[BEAT_WIDTH-1:0];
                    bwrite_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = WR;
                end else if (pmem_read) begin
                    baddr_d = pmem_address & AMASK;
                    bread_d = 1'b1;
                    cnt_d   = '0;
                    state_d = RD;
                end
            end
            RD: begin
                if (burst_resp) begin
                    line_d[cnt_q] = burst_rdata;
                    cnt_d         = cnt_inc;
                    if (cnt_q == LAST) begin
                        bread_d = 1'b0;
                        rdata_d = line_d;
                        resp_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            WR: begin
                if (burst_resp) begin
                    cnt_d = cnt_inc;
                    if (cnt_q == LAST) begin
                        bwrite_d = 1'b0;
                        resp_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        bwdata_d = line_q[cnt_inc];
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            line_q        <= '0;
            pmem_rdata    <= '0;
            pmem_resp     <= 1'b0;
            burst_read    <= 1'b0;
            burst_write   <= 1'b0;
            burst_address <= '0;
            burst_wdata   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            line_q        <= line_d;
            pmem_rdata    <= rdata_d;
            pmem_resp     <= resp_d;
            burst_read    <= bread_d;
            burst_write   <= bwrite_d;
            burst_address <= baddr_d;
            burst_wdata   <= bwdata_d;
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: burst memory responder, scoreboard monitor,
// and directed read/write/reset sequences.
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         burst_read;
    logic         burst_write;
    logic [31:0]  burst_address;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    cacheline_adaptor dut (
        .clk           (clk),
        .rst           (rst),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_address (burst_address),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    typedef struct {
        bit           is_rd;
        logic [255:0] data;
    } resp_t;

    resp_t                exp_resp[$];
    logic [63:0]          exp_beat[$];
    logic [3:0][63:0]     rd_line;
    logic [3:0][63:0]     wline;
    int                   stall_at = -1;
    int                   tests = 0;
    int                   fails = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Burst memory model: updates 1 time unit after each rising edge
    initial begin
        int  idx;
        bit  stalled;
        idx = 0;
        stalled = 0;
        burst_resp = 1'b0;
        burst_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (burst_read || burst_write) begin
                if (idx == stall_at && !stalled) begin
                    burst_resp = 1'b0;
                    stalled = 1;
                end else begin
                    burst_resp = 1'b1;
                    burst_rdata = rd_line[idx[1:0]];
                    idx++;
                end
            end else begin
                burst_resp = 1'b0;
                idx = 0;
                stalled = 0;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pmem_resp) begin
                    if (exp_resp.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_resp: got pmem_resp=1 expected none");
                    end else begin
                        e = exp_resp.pop_front();
                        if (e.is_rd) check("pmem_rdata", pmem_rdata, e.data);
                    end
                end
                if (burst_write) begin
                    if (exp_beat.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_wbeat: got %h expected none", burst_wdata);
                    end else if (burst_resp) begin
                        check("wbeat", burst_wdata, exp_beat.pop_front());
                    end else begin
                        check("wbeat_hold", burst_wdata, exp_beat[0]);
                    end
                end
            end
        end
    end

    task automatic wait_resp(output int n, output logic [31:0] a,
                             output logic [1:0] rw);
        n = 0;
        a = '0;
        rw = '0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                a = burst_address;
                rw = {burst_read, burst_write};
            end
        end while (!pmem_resp && n < 40);
        if (!pmem_resp) begin
            tests++;
            fails++;
            $display("FAIL resp_timeout: got no pmem_resp expected one within 40 cycles");
        end
    endtask

    task automatic push_write(input logic [255:0] line);
        logic [3:0][63:0] l;
        l = line;
        for (int i = 0; i < 4; i++) exp_beat.push_back(l[i]);
        exp_resp.push_back('{1'b0, '0});
    endtask

    initial begin
        int               n;
        int               k;
        logic [31:0]      a;
        logic [1:0]       rw;
        logic [255:0]     line1;

        rst = 1'b1;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        pmem_address = '0;
        pmem_wdata = '0;
        rd_line = '0;
        wline = '0;
        #2;
        check("rst_outs", {pmem_resp, burst_read, burst_write,
                           burst_address, burst_wdata}, '0);
        check("rst_rdata", pmem_rdata, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_rst", {pmem_resp, burst_read, burst_write}, '0);

        // Zero-wait read
        rd_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        line1 = rd_line;
        exp_resp.push_back('{1'b1, rd_line});
        pmem_address = 32'h0000_1234;
        pmem_read = 1'b1;
        wait_resp(n, a, rw);
        pmem_read = 1'b0;
        check("rd_lat", n, 5);
        check("rd_addr", a, 32'h0000_1220);
        check("rd_kind", rw, 2'b10);
        @(posedge clk);
        #1;
        check("resp_one_cycle", pmem_resp, 1'b0);

        // Zero-wait write
        wline = 256'hC0DE0003_DDCCBBAD_C0DE0002_DDCCBBAC_C0DE0001_DDCCBBAB_C0DE0000_DDCCBBAA;
        push_write(wline);
        pmem_wdata = wline;
        pmem_address = 32'h0000_ABCD;
        pmem_write = 1'b1;
        wait_resp(n, a, rw);
        pmem_write = 1'b0;
        check("wr_lat", n, 5);
        check("wr_addr", a, 32'h0000_ABC0);
        check("wr_kind", rw, 2'b01);
        check("rdata_hold", pmem_rdata, line1);
        @(posedge clk);
        #1;

        // Write with one wait cycle before beat 2
        wline = ~wline;
        push_write(wline);
        pmem_wdata = wline;
        stall_at = 2;
        pmem_write = 1'b1;
        wait_resp(n, a, rw);
        pmem_write = 1'b0;
        stall_at = -1;
        check("wr_wait_lat", n, 6);
        @(posedge clk);
        #1;

        // Both requests: writeback first, then the read
        wline = 256'h0123456789ABCDEF_FEDCBA9876543210_0F0F0F0F0F0F0F0F_A5A5A5A5A5A5A5A5;
        push_write(wline);
        rd_line = {64'h8888_0000_0000_0004, 64'h8888_0000_0000_0003,
                   64'h8888_0000_0000_0002, 64'h8888_0000_0000_0001};
        exp_resp.push_back('{1'b1, rd_line});
        pmem_wdata = wline;
        pmem_address = 32'h0000_0040;
        pmem_read = 1'b1;
        pmem_write = 1'b1;
        wait_resp(n, a, rw);
        pmem_write = 1'b0;
        check("both_wr_lat", n, 5);
        check("both_wr_first", rw, 2'b01);
        wait_resp(n, a, rw);
        pmem_read = 1'b0;
        check("both_rd_lat", n, 6);
        @(posedge clk);
        #1;

        // Reset during beat 2 of a read
        rd_line = {64'hDEAD_0000_0000_0004, 64'hDEAD_0000_0000_0003,
                   64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0001};
        pmem_address = 32'h0000_0080;
        pmem_read = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rd_active", burst_read, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outs", {pmem_resp, burst_read, burst_write,
                                 burst_address, burst_wdata}, '0);
        check("async_rst_rdata", pmem_rdata, '0);
        pmem_read = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hold", {pmem_resp, burst_read}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rd_line = {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
                   64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001};
        exp_resp.push_back('{1'b1, rd_line});
        pmem_read = 1'b1;
        wait_resp(n, a, rw);
        pmem_read = 1'b0;
        check("post_rst_lat", n, 5);
        check("post_rst_addr", a, 32'h0000_0080);
        @(posedge clk);
        #1;

        // Back-to-back reads with request held through DONE
        rd_line = {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003,
                   64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001};
        exp_resp.push_back('{1'b1, rd_line});
        pmem_address = 32'h0000_0100;
        pmem_read = 1'b1;
        wait_resp(n, a, rw);
        check("b2b_first_lat", n, 5);
        rd_line = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
                   64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};
        exp_resp.push_back('{1'b1, rd_line});
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!burst_read && k < 20);
        check("b2b_gap", k, 2);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!pmem_resp && n < 40);
        pmem_read = 1'b0;
        check("b2b_second_lat", n, 4);

        repeat (4) @(posedge clk);
        #1;
        check("resp_q_empty", exp_resp.size(), 0);
        check("beat_q_empty", exp_beat.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Line-to-burst bridge on the memory side of the two-way cache.
- Acts as the responder to the cache controller's physical-memory interface (pmem_read/pmem_write/pmem_resp): accepts one full-line read or write and returns a single-cycle pmem_resp.
- Drives a narrower burst memory as the initiator, moving the line as LINE_WIDTH/BEAT_WIDTH beats, lowest beat first.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BEAT_WIDTH, 64, burst data width in bits; must divide LINE_WIDTH. Derived BEATS = LINE_WIDTH/BEAT_WIDTH (4 at defaults).
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pmem_read  in  1  line read request; level, held by cache until pmem_resp.
- pmem_write  in  1  line write request; level, held by cache until pmem_resp.
- pmem_address  in  ADDR_WIDTH  line address from cache.
- pmem_wdata  in  LINE_WIDTH  line to write.
- pmem_rdata  out  LINE_WIDTH  line read; valid when pmem_resp=1 for a read.
- pmem_resp  out  1  one-cycle completion pulse.
- burst_read  out  1  burst read active.
- burst_write  out  1  burst write active.
- burst_address  out  ADDR_WIDTH  line-aligned burst base address.
- burst_wdata  out  BEAT_WIDTH  current write beat.
- burst_rdata  in  BEAT_WIDTH  current read beat.
- burst_resp  in  1  beat accepted/valid this cycle.

Behaviour:
- Reset (async, any state): state=IDLE; beat counter=0; pmem_resp, burst_read, burst_write=0; burst_address, burst_wdata, pmem_rdata, line buffer=0. An in-flight burst is abandoned; no pmem_resp is issued.
- All outputs are registered.
- FSM states: IDLE, RD, WR, DONE.
- IDLE: requests are sampled only here.
  - pmem_write=1 → latch pmem_wdata, set burst_address = pmem_address with low log2(LINE_WIDTH/8) bits cleared, go WR. Write takes priority when both requests are high (dirty writeback first).
  - Else pmem_read=1 → latch aligned address, go RD.
  - burst_resp in IDLE is ignored.
- RD: burst_read=1 from the cycle after acceptance.
  - Each cycle with burst_resp=1 stores burst_rdata into beat[count] (beat 0 = bits BEAT_WIDTH-1:0) and increments count.
  - On beat BEATS-1: burst_read drops at that edge, pmem_rdata takes the full assembled line, go DONE.
  - burst_resp=0 holds all state (unbounded wait states).
- WR: burst_write=1 and burst_wdata = beat[count] of the latched line.
  - burst_resp=1 advances to the next beat (burst_wdata updates at the same edge).
  - After beat BEATS-1: burst_write drops, go DONE.
- DONE: pmem_resp=1 for exactly one cycle, then IDLE.
  - Requests still high during DONE are not accepted; the earliest re-accept is the following IDLE cycle.
  - pmem_rdata holds its value until the next read completes.
- Latency with zero-wait memory, accept at edge 0: burst cycles 1..BEATS, pmem_resp in cycle BEATS+1 (cycle 5 at defaults). Each wait cycle adds one cycle.
- Beat counter width is log2(BEATS); it wraps to 0 on the final beat.
- burst_address is constant for the whole burst; the burst memory applies the per-beat offset.

Test Plan:
- Reset: assert rst mid-cycle with no clock → all outputs 0 immediately; state IDLE after release.
- Zero-wait read, pmem_address=0x0000_1234: burst_address=0x0000_1220; beats 0x11..,0x22..,0x33..,0x44.. → pmem_rdata={0x44..,0x33..,0x22..,0x11..}; pmem_resp high in cycle 5 only.
- Write with pmem_wdata=256'h…DDCCBBAA pattern → burst_wdata walks beat0..beat3 in order. With one wait cycle before beat 2, beat 2 is held two cycles and pmem_resp is delayed by one.
- pmem_read=pmem_write=1 in IDLE → write burst runs first, then exactly one pmem_resp. Read is accepted only after DONE, if the cache is still requesting.
- rst asserted during the beat-2 read → burst_read drops at once, no pmem_resp. A new read after release completes normally with fresh data.
- Back-to-back reads with requests held through DONE → second burst_read rises no earlier than 2 cycles after the first pmem_resp; each read produces exactly one pmem_resp.
